// File: rtl/alu_sub_seq.sv
// Multi-word subtract sequencer: walks the operand words LSB-first through an
// external single-word ALU, chaining the borrow and committing the full result.
module alu_sub_seq #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BITS*WORDS-1:0] i_a,
  input  logic [BITS*WORDS-1:0] i_b,
  input  logic                  i_carry,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BITS*WORDS-1:0] o_result,
  output logic                  o_carry,
  output logic                  o_zero,
  output logic [BITS-1:0]       o_alu_a,
  output logic [BITS-1:0]       o_alu_b,
  output logic                  o_alu_carry,
  input  logic [BITS-1:0]       i_alu_sub,
  input  logic                  i_alu_carry
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [WORDS-1:0][BITS-1:0]  a_q, b_q, shadow, shadow_nxt;
  logic                        crr;
  logic                        last;

  assign last = (idx == IW'(WORDS - 1));

  // Shadow as it will look after this edge, so the last word commits on the same edge.
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = i_alu_sub;
  end

  assign o_busy      = (state == RUN);
  assign o_done      = (state == DONE);
  assign o_alu_a     = o_busy ? a_q[idx] : '0;
  assign o_alu_b     = o_busy ? b_q[idx] : '0;
  assign o_alu_carry = o_busy & crr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      crr      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow   <= '0;
      o_result <= '0;
      o_carry  <= 1'b0;
      o_zero   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            a_q   <= i_a;
            b_q   <= i_b;
            crr   <= i_carry;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (i_abort) begin
            // Partial words are thrown away; committed outputs stay untouched.
            state  <= IDLE;
            idx    <= '0;
            crr    <= 1'b0;
            shadow <= '0;
          end else begin
            shadow <= shadow_nxt;
            crr    <= i_alu_carry;
            if (last) begin
              idx      <= '0;
              state    <= DONE;
              o_result <= shadow_nxt;
              o_carry  <= i_alu_carry;
              o_zero   <= (shadow_nxt == '0);
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sub_seq.sv
// Scoreboard bench for alu_sub_seq with a behavioural single-word ALU attached.
module tb_alu_sub_seq;
  localparam int BITS  = 8;
  localparam int WORDS = 2;
  localparam int W     = BITS * WORDS;

  logic            clk = 0, rst_n = 0, start = 0, carry_in = 0, abort = 0;
  logic [W-1:0]    a = '0, b = '0;
  logic            busy, done, res_c, res_z, alu_c, alu_cout;
  logic [W-1:0]    result;
  logic [BITS-1:0] alu_a, alu_b, alu_sub;
  logic [BITS:0]   alu_full;

  // ALU: sub = (a - b - carry) mod 2^BITS, carry out = borrow
  assign alu_full = {1'b0, alu_a} - {1'b0, alu_b} - {{BITS{1'b0}}, alu_c};
  assign alu_sub  = alu_full[BITS-1:0];
  assign alu_cout = alu_full[BITS];

  alu_sub_seq #(.BITS(BITS), .WORDS(WORDS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .i_carry(carry_in), .i_abort(abort), .o_busy(busy), .o_done(done),
    .o_result(result), .o_carry(res_c), .o_zero(res_z),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_carry(alu_c),
    .i_alu_sub(alu_sub), .i_alu_carry(alu_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  logic [W-1:0] c_res = '0;
  logic         c_c = 1'b0, c_z = 1'b1;
  int           total = 0, bad = 0;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    exp_t       e;
    logic [W:0] d;
    d   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
    e.r = d[W-1:0];
    e.c = d[W];
    e.z = (d[W-1:0] == '0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops on o_done, otherwise committed outputs must hold.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done act=1 exp=0 t=%0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("sb_result", 32'(result), 32'(mon_e.r));
        chk("sb_carry", 32'(res_c), 32'(mon_e.c));
        chk("sb_zero", 32'(res_z), 32'(mon_e.z));
        c_res = mon_e.r; c_c = mon_e.c; c_z = mon_e.z;
      end
    end else begin
      chk("hold_result", 32'(result), 32'(c_res));
      chk("hold_carry", 32'(res_c), 32'(c_c));
      chk("hold_zero", 32'(res_z), 32'(c_z));
    end
  end

  // Issue a start from IDLE; returns at the first RUN-cycle sample.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; carry_in = tc; start = 1;
    q.push_back(model(ta, tb, tc));
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout act=0 exp=1 t=%0t", $time);
    end
  endtask

  task automatic do_abort(input int k);
    repeat (k) @(negedge clk);
    abort = 1;
    void'(q.pop_back());
    @(negedge clk);
    abort = 0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_nodone", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int mode;
    logic [W-1:0] ra, rb;
    logic rc;

    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(res_c), 32'd0);
    chk("rst_zero", 32'(res_z), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_c}), 32'd0);
    rst_n = 1;

    // word sequencing and latency
    start_op(16'h0100, 16'h0001, 1'b0);
    chk("w0_drive", 32'({alu_a, alu_b, alu_c}), 32'({8'h00, 8'h01, 1'b0}));
    chk("w0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("w1_drive", 32'({alu_a, alu_b, alu_c}), 32'({8'h01, 8'h00, 1'b1}));
    wait_done(2, n);
    chk("latency", 32'(n), 32'(WORDS + 1));
    chk("r038", 32'({result, res_c, res_z}), 32'({16'h00FF, 1'b0, 1'b0}));
    chk("done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_alu", 32'({alu_a, alu_b, alu_c, busy, done}), 32'd0);

    start_op(16'h1234, 16'h1234, 1'b0);
    wait_done(1, n);
    chk("r039", 32'({result, res_c, res_z}), 32'({16'h0000, 1'b0, 1'b1}));

    // back-to-back through DONE
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(1, n);
    chk("r040a", 32'({result, res_c}), 32'({16'hFFFF, 1'b1}));
    a = 16'h0005; b = 16'h0003; carry_in = 0; start = 1;
    q.push_back(model(16'h0005, 16'h0003, 1'b0));
    @(negedge clk);
    start = 0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1, n);
    chk("b2b_period", 32'(n), 32'(WORDS + 1));
    chk("r040b", 32'({result, res_c}), 32'({16'h0002, 1'b0}));

    // start during RUN is ignored
    start_op(16'h0A0B, 16'h0102, 1'b1);
    a = 16'hFFFF; b = 16'h0000; carry_in = 0; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(2, n);
    chk("r041", 32'({result, res_c}), 32'({16'h0908, 1'b0}));

    // abort on last word
    start_op(16'h5555, 16'h1111, 1'b0);
    do_abort(WORDS - 1);
    chk("r042_keep", 32'(result), 32'h0908);
    repeat (4) @(negedge clk);

    // async reset mid-RUN
    start_op(16'h2000, 16'h0001, 1'b0);
    #2 rst_n = 0;
    q.delete();
    c_res = '0; c_c = 1'b0; c_z = 1'b1;
    #1;
    chk("r043_out", 32'({result, res_c, res_z, busy, done}), 32'({16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}));
    chk("r043_alu", 32'({alu_a, alu_b, alu_c}), 32'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("r043_idle", 32'(busy), 32'd0);

    // randomized operations with occasional aborts
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = '0; rb = '0; rc = 1'b1; end
      if (i == 1) begin ra = '1; rb = '0; rc = 1'b1; end
      mode = $urandom_range(0, 3);
      start_op(ra, rb, rc);
      if (mode == 0) do_abort($urandom_range(0, WORDS - 1));
      else begin
        wait_done(1, n);
        chk("rnd_latency", 32'(n), 32'(WORDS + 1));
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
endmodule
